// File: rtl/ofs_plat_axi_mem_if_outstanding_limit.sv
// Limits the number of AXI write and read bursts in flight by gating AW/AR
// against registered outstanding counters that retire on B and R-last.
module ofs_plat_axi_mem_if_outstanding_limit #(
  parameter int AW_WIDTH      = 64,
  parameter int AR_WIDTH      = 64,
  parameter int MAX_WR_BURSTS = 16,
  parameter int MAX_RD_BURSTS = 16,
  localparam int CW_WR = $clog2(MAX_WR_BURSTS + 1),
  localparam int CW_RD = $clog2(MAX_RD_BURSTS + 1)
) (
  input  logic                clk,
  input  logic                reset,

  input  logic                src_awvalid,
  input  logic [AW_WIDTH-1:0] src_aw,
  output logic                src_awready,
  output logic                snk_awvalid,
  output logic [AW_WIDTH-1:0] snk_aw,
  input  logic                snk_awready,

  input  logic                src_arvalid,
  input  logic [AR_WIDTH-1:0] src_ar,
  output logic                src_arready,
  output logic                snk_arvalid,
  output logic [AR_WIDTH-1:0] snk_ar,
  input  logic                snk_arready,

  input  logic                bvalid,
  input  logic                bready,
  input  logic                rvalid,
  input  logic                rready,
  input  logic                rlast,

  output logic [CW_WR-1:0]    wr_outstanding,
  output logic [CW_RD-1:0]    rd_outstanding,
  output logic                wr_full,
  output logic                rd_full,
  output logic                idle,
  output logic                err_underflow
);

  logic [CW_WR-1:0] wr_cnt_q, wr_cnt_d;
  logic [CW_RD-1:0] rd_cnt_q, rd_cnt_d;
  logic             err_q, err_d;

  logic aw_fire, b_fire, ar_fire, r_done;

  // Full is taken from the registered count only, so a retiring B/R-last
  // never reaches the ready outputs combinationally.
  assign wr_full = (wr_cnt_q == CW_WR'(MAX_WR_BURSTS));
  assign rd_full = (rd_cnt_q == CW_RD'(MAX_RD_BURSTS));

  assign snk_awvalid = src_awvalid & ~wr_full & ~reset;
  assign src_awready = snk_awready & ~wr_full & ~reset;
  assign snk_arvalid = src_arvalid & ~rd_full & ~reset;
  assign src_arready = snk_arready & ~rd_full & ~reset;

  assign snk_aw = src_aw;
  assign snk_ar = src_ar;

  assign aw_fire = snk_awvalid & snk_awready;
  assign b_fire  = bvalid & bready;
  assign ar_fire = snk_arvalid & snk_arready;
  assign r_done  = rvalid & rready & rlast;

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    err_d    = err_q;

    if (aw_fire && !b_fire) begin
      wr_cnt_d = wr_cnt_q + CW_WR'(1);
    end else if (!aw_fire && b_fire) begin
      // A retire with nothing outstanding holds the count at zero and flags it.
      if (wr_cnt_q == '0) err_d = 1'b1;
      else                wr_cnt_d = wr_cnt_q - CW_WR'(1);
    end

    if (ar_fire && !r_done) begin
      rd_cnt_d = rd_cnt_q + CW_RD'(1);
    end else if (!ar_fire && r_done) begin
      if (rd_cnt_q == '0) err_d = 1'b1;
      else                rd_cnt_d = rd_cnt_q - CW_RD'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      err_q    <= err_d;
    end
  end

  assign wr_outstanding = wr_cnt_q;
  assign rd_outstanding = rd_cnt_q;
  assign idle           = (wr_cnt_q == '0) && (rd_cnt_q == '0);
  assign err_underflow  = err_q;

endmodule

// File: tb/tb_ofs_plat_axi_mem_if_outstanding_limit.sv
// Bench for the outstanding-burst limiter: a cycle-by-cycle vector table for
// the directed corner cases, then a randomized phase checked against a model.
module tb_ofs_plat_axi_mem_if_outstanding_limit;
  localparam int AWW  = 8;
  localparam int ARW  = 8;
  localparam int MAXW = 4;
  localparam int MAXR = 4;

  logic clk = 1'b0;
  logic reset;
  logic src_awvalid, src_awready, snk_awvalid, snk_awready;
  logic src_arvalid, src_arready, snk_arvalid, snk_arready;
  logic [AWW-1:0] src_aw, snk_aw;
  logic [ARW-1:0] src_ar, snk_ar;
  logic bvalid, bready, rvalid, rready, rlast;
  logic [2:0] wr_outstanding, rd_outstanding;
  logic wr_full, rd_full, idle, err_underflow;

  ofs_plat_axi_mem_if_outstanding_limit #(
    .AW_WIDTH(AWW), .AR_WIDTH(ARW), .MAX_WR_BURSTS(MAXW), .MAX_RD_BURSTS(MAXR)
  ) dut (
    .clk(clk), .reset(reset),
    .src_awvalid(src_awvalid), .src_aw(src_aw), .src_awready(src_awready),
    .snk_awvalid(snk_awvalid), .snk_aw(snk_aw), .snk_awready(snk_awready),
    .src_arvalid(src_arvalid), .src_ar(src_ar), .src_arready(src_arready),
    .snk_arvalid(snk_arvalid), .snk_ar(snk_ar), .snk_arready(snk_arready),
    .bvalid(bvalid), .bready(bready), .rvalid(rvalid), .rready(rready), .rlast(rlast),
    .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding),
    .wr_full(wr_full), .rd_full(rd_full), .idle(idle), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  // hs = {src_awready, snk_awvalid, src_arready, snk_arvalid}
  // flags = {wr_full, rd_full, idle, err_underflow}
  typedef struct packed {
    logic [3:0]     hs;
    logic [2:0]     wr;
    logic [2:0]     rd;
    logic [3:0]     flags;
    logic [AWW-1:0] aw;
    logic [ARW-1:0] ar;
  } obs_t;

  // stim = {reset, awvalid, snk_awready, arvalid, snk_arready, bvalid, bready, rvalid, rready, rlast}
  typedef struct {
    logic [9:0] stim;
    logic [3:0] hs;
    int         wr;
    int         rd;
    logic [3:0] flags;
  } vec_t;

  typedef struct {
    string name;
    obs_t  e;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];
  int   checks = 0;
  int   errors = 0;

  int   wr_m, rd_m;
  logic err_m;
  logic [9:0] s;

  task automatic add(input logic [9:0] st, input logic [3:0] hs, input int wr, input int rd,
                     input logic [3:0] flags);
    vec_t v;
    v.stim = st; v.hs = hs; v.wr = wr; v.rd = rd; v.flags = flags;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [9:0] st);
    {reset, src_awvalid, snk_awready, src_arvalid, snk_arready,
     bvalid, bready, rvalid, rready, rlast} = st;
    src_aw = AWW'($urandom);
    src_ar = ARW'($urandom);
  endtask

  task automatic push_exp(input string name, input logic [3:0] hs, input int wr, input int rd,
                          input logic [3:0] flags);
    sb_t t;
    t.name = name;
    t.e = '{hs: hs, wr: 3'(wr), rd: 3'(rd), flags: flags, aw: src_aw, ar: src_ar};
    sb.push_back(t);
  endtask

  task automatic pop_check();
    sb_t  t;
    obs_t got;
    got = '{hs: {src_awready, snk_awvalid, src_arready, snk_arvalid},
            wr: wr_outstanding, rd: rd_outstanding,
            flags: {wr_full, rd_full, idle, err_underflow},
            aw: snk_aw, ar: snk_ar};
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %h required a queued expectation", got);
      return;
    end
    t = sb.pop_front();
    if (got !== t.e) begin
      errors++;
      $display("FAIL %s: got hs=%b wr=%0d rd=%0d flags=%b aw=%h ar=%h, required hs=%b wr=%0d rd=%0d flags=%b aw=%h ar=%h",
               t.name, got.hs, got.wr, got.rd, got.flags, got.aw, got.ar,
               t.e.hs, t.e.wr, t.e.rd, t.e.flags, t.e.aw, t.e.ar);
    end else begin
      $display("ok %s: hs=%b wr=%0d rd=%0d flags=%b", t.name, got.hs, got.wr, got.rd, got.flags);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(10'b1_0_1_0_1_00000);
    repeat (2) @(posedge clk);

    // reset row with valids asserted, then the read fill/release sequence
    add(10'b1_1_1_1_1_00000, 4'b0000, 0, 0, 4'b0010);
    add(10'b0_0_1_0_1_00000, 4'b1010, 0, 0, 4'b0010);
    add(10'b0_0_1_1_1_00000, 4'b1011, 0, 0, 4'b0010);
    add(10'b0_0_1_1_1_00000, 4'b1011, 0, 1, 4'b0000);
    add(10'b0_0_1_1_1_00000, 4'b1011, 0, 2, 4'b0000);
    add(10'b0_0_1_1_1_00000, 4'b1011, 0, 3, 4'b0000);
    add(10'b0_0_1_1_1_00000, 4'b1000, 0, 4, 4'b0100);
    add(10'b0_0_1_1_1_00000, 4'b1000, 0, 4, 4'b0100);
    // AR pending while full, R-last in the same cycle: not accepted
    add(10'b0_0_1_1_1_00111, 4'b1000, 0, 4, 4'b0100);
    add(10'b0_0_1_1_1_00000, 4'b1011, 0, 3, 4'b0000);
    add(10'b0_0_1_1_1_00000, 4'b1000, 0, 4, 4'b0100);
    // R beat without last leaves the count alone
    add(10'b0_0_1_0_1_00110, 4'b1000, 0, 4, 4'b0100);
    add(10'b0_0_1_0_1_00111, 4'b1000, 0, 4, 4'b0100);
    add(10'b0_0_1_1_1_00000, 4'b1011, 0, 3, 4'b0000);
    add(10'b0_0_1_0_1_00000, 4'b1000, 0, 4, 4'b0100);
    add(10'b0_0_1_0_1_00111, 4'b1000, 0, 4, 4'b0100);
    add(10'b0_0_1_0_1_00111, 4'b1010, 0, 3, 4'b0000);
    add(10'b0_0_1_0_1_00111, 4'b1010, 0, 2, 4'b0000);
    add(10'b0_0_1_0_1_00111, 4'b1010, 0, 1, 4'b0000);
    add(10'b0_0_1_0_1_00000, 4'b1010, 0, 0, 4'b0010);
    // writes: simultaneous AW and B at count 2
    add(10'b0_1_1_0_1_00000, 4'b1110, 0, 0, 4'b0010);
    add(10'b0_1_1_0_1_00000, 4'b1110, 1, 0, 4'b0000);
    add(10'b0_1_1_0_1_11000, 4'b1110, 2, 0, 4'b0000);
    add(10'b0_0_1_0_1_00000, 4'b1010, 2, 0, 4'b0000);
    add(10'b0_0_1_0_1_11000, 4'b1010, 2, 0, 4'b0000);
    add(10'b0_0_1_0_1_11000, 4'b1010, 1, 0, 4'b0000);
    add(10'b0_0_1_0_1_00000, 4'b1010, 0, 0, 4'b0010);
    // B underflow, sticky error
    add(10'b0_0_1_0_1_11000, 4'b1010, 0, 0, 4'b0010);
    add(10'b0_0_1_0_1_00000, 4'b1010, 0, 0, 4'b0011);
    add(10'b0_0_1_0_1_00111, 4'b1010, 0, 0, 4'b0011);
    add(10'b0_1_1_0_1_00000, 4'b1110, 0, 0, 4'b0011);
    add(10'b0_1_1_0_1_00000, 4'b1110, 1, 0, 4'b0001);
    add(10'b0_1_1_0_1_00000, 4'b1110, 2, 0, 4'b0001);
    add(10'b0_0_1_0_1_00000, 4'b1010, 3, 0, 4'b0001);
    // reset with 3 writes outstanding
    add(10'b1_1_1_1_1_00000, 4'b0000, 3, 0, 4'b0001);
    add(10'b0_0_1_0_1_00000, 4'b1010, 0, 0, 4'b0010);
    // R-last underflow
    add(10'b0_0_1_0_1_00111, 4'b1010, 0, 0, 4'b0010);
    add(10'b0_0_1_0_1_00000, 4'b1010, 0, 0, 4'b0011);
    add(10'b1_0_1_0_1_00000, 4'b0000, 0, 0, 4'b0011);
    // AW fire and B at count 0: no underflow
    add(10'b0_1_1_0_1_11000, 4'b1110, 0, 0, 4'b0010);
    add(10'b0_0_1_0_1_00000, 4'b1010, 0, 0, 4'b0010);
    add(10'b0_1_1_0_1_00000, 4'b1110, 0, 0, 4'b0010);
    add(10'b0_1_1_0_1_00000, 4'b1110, 1, 0, 4'b0000);
    add(10'b0_1_1_0_1_00000, 4'b1110, 2, 0, 4'b0000);
    add(10'b0_1_1_0_1_00000, 4'b1110, 3, 0, 4'b0000);
    add(10'b0_1_1_0_1_00000, 4'b0010, 4, 0, 4'b1000);
    add(10'b0_1_0_0_1_00000, 4'b0010, 4, 0, 4'b1000);
    add(10'b0_0_1_0_1_11000, 4'b0010, 4, 0, 4'b1000);
    // sink not ready below full: valid passes, no accept
    add(10'b0_1_0_0_1_00000, 4'b0110, 3, 0, 4'b0000);
    add(10'b0_1_1_0_1_00000, 4'b1110, 3, 0, 4'b0000);
    add(10'b0_0_1_0_1_00000, 4'b0010, 4, 0, 4'b1000);

    foreach (vecs[k]) begin
      @(posedge clk); #1;
      drive(vecs[k].stim);
      push_exp($sformatf("vec%0d", k), vecs[k].hs, vecs[k].wr, vecs[k].rd, vecs[k].flags);
      @(negedge clk);
      pop_check();
    end

    // randomized phase: start from a reset, then compare against a counter model
    @(posedge clk); #1;
    drive(10'b1_0_1_0_1_00000);
    @(posedge clk); #1;
    wr_m = 0; rd_m = 0; err_m = 1'b0;
    for (int n = 0; n < 200; n++) begin
      logic rst, awv, awr, arv, arr, bv, br, rv, rr, rl, wf, rf, awf, bd, arf, rd;
      if (n != 0) begin
        @(posedge clk); #1;
      end
      rst = ($urandom_range(0, 40) == 0);
      awv = ($urandom_range(0, 9) < 7);
      awr = ($urandom_range(0, 9) < 8);
      arv = ($urandom_range(0, 9) < 7);
      arr = ($urandom_range(0, 9) < 8);
      bv  = ($urandom_range(0, 9) < 4);
      br  = ($urandom_range(0, 9) < 7);
      rv  = ($urandom_range(0, 9) < 5);
      rr  = ($urandom_range(0, 9) < 8);
      rl  = ($urandom_range(0, 9) < 6);
      s = {rst, awv, awr, arv, arr, bv, br, rv, rr, rl};
      drive(s);
      wf = (wr_m == MAXW);
      rf = (rd_m == MAXR);
      push_exp($sformatf("rand%0d", n),
               {awr & ~wf & ~rst, awv & ~wf & ~rst, arr & ~rf & ~rst, arv & ~rf & ~rst},
               wr_m, rd_m, {wf, rf, (wr_m == 0 && rd_m == 0), err_m});
      @(negedge clk);
      pop_check();
      if (rst) begin
        wr_m = 0; rd_m = 0; err_m = 1'b0;
      end else begin
        awf = awv & awr & ~wf;
        bd  = bv & br;
        arf = arv & arr & ~rf;
        rd  = rv & rr & rl;
        if (awf && !bd) wr_m++;
        else if (!awf && bd) begin
          if (wr_m == 0) err_m = 1'b1;
          else wr_m--;
        end
        if (arf && !rd) rd_m++;
        else if (!arf && rd) begin
          if (rd_m == 0) err_m = 1'b1;
          else rd_m--;
        end
      end
    end

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
